// File: rtl/core_if_queue_if.sv
// Handshake bundle for core_if_queue: redirect input, instruction-memory
// request/response channel and the decode-side queue head.
interface core_if_queue_if #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             redirect;
    logic [63:0]      redirect_pc;
    logic             imem_req_valid;
    logic [63:0]      imem_req_addr;
    logic             imem_req_ready;
    logic             imem_resp_valid;
    logic [31:0]      imem_resp_inst;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [63:0]      out_pc;
    logic [63:0]      out_pc4;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_inst, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_inst,
               out_pc, out_pc4, count
    );

    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_inst, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_inst,
               out_pc, out_pc4, count
    );
endinterface

// File: rtl/core_if_queue.sv
// Fetch stage: in-order instruction-memory requests feeding a DEPTH-entry
// instruction queue, with redirect flush and stale-response dropping.
module core_if_queue #(
    parameter logic [63:0] RESET_PC        = 64'h100,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          CNT_W           = $clog2(DEPTH + 1)
) (
    input logic            clock,
    input logic            reset_n,
    core_if_queue_if.master bus
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W:0]  DEPTH_C = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W - 1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PONE_C = {{(PTR_W - 1){1'b0}}, 1'b1};

    logic [63:0]      fetch_pc_r;
    logic [63:0]      resp_pc_r;
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] stale_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [31:0]      inst_mem_r [DEPTH];
    logic [63:0]      pc_mem_r   [DEPTH];

    logic [CNT_W:0]   credit_s;
    logic             req_valid_s;
    logic             accept_s;
    logic             drop_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [CNT_W-1:0] resp_dec_s;
    logic [CNT_W-1:0] accept_inc_s;
    logic [CNT_W-1:0] push_inc_s;
    logic [CNT_W-1:0] pop_dec_s;

    // Issue credit, handshakes and queue push/pop qualifiers.
    always_comb begin
        // Every live response already owns a queue slot, so the queue cannot overflow.
        credit_s     = {1'b0, count_r} + {1'b0, inflight_r} - {1'b0, stale_r};
        req_valid_s  = reset_n & ~bus.redirect & (inflight_r < MAX_C) & (credit_s < DEPTH_C);
        accept_s     = req_valid_s & bus.imem_req_ready;
        drop_s       = bus.imem_resp_valid & (stale_r != ZERO_C);
        push_s       = bus.imem_resp_valid & ~drop_s & ~bus.redirect;
        head_valid_s = (count_r != ZERO_C);
        pop_s        = head_valid_s & bus.out_ready & ~bus.redirect;
        resp_dec_s   = {{(CNT_W - 1){1'b0}}, bus.imem_resp_valid};
        accept_inc_s = {{(CNT_W - 1){1'b0}}, accept_s};
        push_inc_s   = {{(CNT_W - 1){1'b0}}, push_s};
        pop_dec_s    = {{(CNT_W - 1){1'b0}}, pop_s};
    end

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.out_valid      = head_valid_s;
    assign bus.out_inst       = head_valid_s ? inst_mem_r[head_r] : 32'h0;
    assign bus.out_pc         = head_valid_s ? pc_mem_r[head_r] : 64'h0;
    assign bus.out_pc4        = head_valid_s ? (pc_mem_r[head_r] + 64'd4) : 64'h0;
    assign bus.count          = count_r;

    // Fetch/response PCs, outstanding-request accounting and the queue storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            inflight_r <= ZERO_C;
            stale_r    <= ZERO_C;
            count_r    <= ZERO_C;
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_r[i] <= 32'h0;
                pc_mem_r[i]   <= 64'h0;
            end
        end else if (bus.redirect) begin
            // A response arriving now is already stale, so it is not counted in stale.
            fetch_pc_r <= bus.redirect_pc;
            resp_pc_r  <= bus.redirect_pc;
            inflight_r <= inflight_r - resp_dec_s;
            stale_r    <= inflight_r - resp_dec_s;
            count_r    <= ZERO_C;
            head_r     <= tail_r;
        end else begin
            if (accept_s) begin
                fetch_pc_r <= fetch_pc_r + 64'd4;
            end
            inflight_r <= inflight_r + accept_inc_s - resp_dec_s;
            if (drop_s) begin
                stale_r <= stale_r - ONE_C;
            end
            if (push_s) begin
                inst_mem_r[tail_r] <= bus.imem_resp_inst;
                pc_mem_r[tail_r]   <= resp_pc_r;
                tail_r             <= tail_r + PONE_C;
                resp_pc_r          <= resp_pc_r + 64'd4;
            end
            if (pop_s) begin
                head_r <= head_r + PONE_C;
            end
            count_r <= count_r + push_inc_s - pop_dec_s;
        end
    end
endmodule

// File: tb/tb_core_if_queue.sv
// Directed bench for core_if_queue: latency-configurable in-order memory model
// plus a scoreboard of expected {pc, inst} pushed on each accepted request.
module tb_core_if_queue;
    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    logic        clock;
    logic        reset_n;
    int          cmp;
    int          mis;
    int          cyc;
    int          mem_lat;
    int          pops;
    logic [63:0] exp_fetch;
    pend_t       pend_q[$];
    logic [63:0] exp_q[$];

    core_if_queue_if #(.DEPTH(4)) bus ();

    core_if_queue #(
        .RESET_PC(64'h100),
        .DEPTH(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return 32'hC0DE0000 ^ a[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp)
        else begin
            mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with inputs set; runs one clock cycle.
    task automatic tick();
        logic        acc;
        logic        red;
        logic [63:0] a;
        logic [63:0] rpc;
        logic [63:0] e;
        int          exp_stale;
        pend_t       p;
        exp_stale = 0;
        #4;
        acc = bus.imem_req_valid && bus.imem_req_ready;
        a   = bus.imem_req_addr;
        red = bus.redirect;
        rpc = bus.redirect_pc;
        if (acc) begin
            chk("req_addr", a, exp_fetch);
            exp_fetch = exp_fetch + 64'd4;
            exp_q.push_back(a);
        end
        if (!red && bus.out_valid && bus.out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
            chk("pop_pc", bus.out_pc, e);
            chk("pop_inst", {32'h0, bus.out_inst}, {32'h0, inst_of(e)});
            chk("pop_pc4", bus.out_pc4, e + 64'd4);
            pops++;
        end
        if (red) begin
            chk("no_req_in_redirect", {63'h0, bus.imem_req_valid}, 64'h0);
            exp_stale = pend_q.size();
            exp_q.delete();
            exp_fetch = rpc;
        end
        @(posedge clock);
        #1;
        cyc++;
        if (acc) begin
            p.addr = a;
            p.due  = cyc - 1 + mem_lat;
            pend_q.push_back(p);
        end
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            p = pend_q.pop_front();
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_inst  = inst_of(p.addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_inst  = 32'h0;
        end
        if (red) begin
            chk("redir_stale", 64'(dut.stale_r), 64'(exp_stale));
            chk("redir_count", 64'(bus.count), 64'h0);
            chk("redir_out_valid", {63'h0, bus.out_valid}, 64'h0);
            chk("redir_next_addr", bus.imem_req_addr, rpc);
        end
        bus.redirect = 1'b0;
    endtask

    initial begin
        int n;
        cmp = 0; mis = 0; cyc = 0; mem_lat = 1; pops = 0;
        exp_fetch = 64'h100;
        reset_n = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst = 32'h0;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1;
        chk("rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_out_pc", bus.out_pc, 64'h0);
        chk("rst_out_pc4", bus.out_pc4, 64'h0);
        chk("rst_out_inst", {32'h0, bus.out_inst}, 64'h0);

        // Streaming: ready memory, 1-cycle latency, decode always ready.
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("first_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("first_req_addr", bus.imem_req_addr, 64'h100);
        tick();
        tick();
        chk("cycle3_valid", {63'h0, bus.out_valid}, 64'h1);
        chk("cycle3_pc", bus.out_pc, 64'h100);
        chk("cycle3_pc4", bus.out_pc4, 64'h104);
        chk("cycle3_inst", {32'h0, bus.out_inst}, {32'h0, inst_of(64'h100)});
        pops = 0;
        repeat (10) tick();
        chk("throughput", 64'(pops), 64'd10);

        // Backpressure: queue fills, issue stops once every slot is reserved.
        bus.out_ready = 1'b0;
        repeat (8) tick();
        chk("bp_count", 64'(bus.count), 64'd4);
        chk("bp_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        bus.out_ready = 1'b1;
        pops = 0;
        repeat (10) tick();
        chk("bp_drain", 64'(pops >= 4), 64'h1);

        // Redirect with two requests in flight and no response that cycle.
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        mem_lat = 3;
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h2000;
        tick();
        bus.imem_req_ready = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("redir1_first_pc", bus.out_pc, 64'h2000);
        chk("redir1_stale_drained", 64'(dut.stale_r), 64'h0);

        // Redirect coinciding with a response and a pop.
        bus.imem_req_ready = 1'b0;
        repeat (6) tick();
        mem_lat = 2;
        bus.imem_req_ready = 1'b1;
        bus.out_ready = 1'b0;
        repeat (5) tick();
        chk("redir2_head_valid", {63'h0, bus.out_valid}, 64'h1);
        bus.out_ready = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h2000;
        tick();
        n = 0;
        while (!bus.out_valid && n < 30) begin
            tick();
            n++;
        end
        chk("redir2_first_pc", bus.out_pc, 64'h2000);

        // Wrap-around with random decode backpressure.
        mem_lat = 1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 64'h100;
        tick();
        pops = 0;
        n = 0;
        while (pops < 10 && n < 300) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        chk("wrap_pops", 64'(pops >= 10), 64'h1);

        // Asynchronous reset mid-stream.
        bus.out_ready = 1'b1;
        mem_lat = 3;
        repeat (6) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_out_valid", {63'h0, bus.out_valid}, 64'h0);
        chk("async_req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
        chk("async_count", 64'(bus.count), 64'h0);
        pend_q.delete();
        exp_q.delete();
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst = 32'h0;
        exp_fetch = 64'h100;
        mem_lat = 1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        #1;
        chk("post_rst_req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
        chk("post_rst_req_addr", bus.imem_req_addr, 64'h100);
        pops = 0;
        repeat (8) tick();
        chk("post_rst_stream", 64'(pops >= 4), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
